// File: rtl/fft_pkg.sv
// fft_pkg: constants and types shared by the streaming FFT stages.
//   FFT_N        transform length in samples
//   LANES        complex samples carried per beat
//   HALF_DEPTH   beats per half-frame (stage-0 delay buffer depth)
//   WIDTH        MSB index of stage-0 output samples (input width)
//   bfly_state_t stage-0 butterfly FSM state
//   s_in_t       stage-0 input sample  <3.6>
//   s_out_t      stage-0 output sample <4.6>, one bit of growth
package fft_pkg;

    localparam int FFT_N      = 512;
    localparam int LANES      = 16;
    localparam int HALF_DEPTH = 16;
    localparam int WIDTH      = 9;
    localparam int CLK_CNT    = 5;

    typedef enum logic {
        FILL = 1'b0,
        CALC = 1'b1
    } bfly_state_t;

    typedef logic signed [WIDTH-1:0] s_in_t;
    typedef logic signed [WIDTH:0]   s_out_t;

endpackage

// File: rtl/bfly00_dly_buf.sv
// bfly00_dly_buf: half-frame delay buffer for the stage-0 butterfly.
// HALF_DEPTH rows of LANES complex samples; synchronous write, combinational
// read. Contents are deliberately not reset: every row is written during
// FILL before CALC reads it.
//   clk            system clock
//   we             write the lane arrays into row addr on this edge
//   addr           row address (shared by write and read)
//   wr_re, wr_im   lane samples to write
//   rd_re, rd_im   lane samples currently stored at addr
module bfly00_dly_buf #(
    parameter int WIDTH      = 9,
    parameter int LANES      = 16,
    parameter int HALF_DEPTH = 16,
    parameter int AW         = $clog2(HALF_DEPTH)
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [AW-1:0]           addr,
    input  logic signed [WIDTH-1:0] wr_re [0:LANES-1],
    input  logic signed [WIDTH-1:0] wr_im [0:LANES-1],
    output logic signed [WIDTH-1:0] rd_re [0:LANES-1],
    output logic signed [WIDTH-1:0] rd_im [0:LANES-1]
);

    logic signed [WIDTH-1:0] mem_re [0:HALF_DEPTH-1][0:LANES-1];
    logic signed [WIDTH-1:0] mem_im [0:HALF_DEPTH-1][0:LANES-1];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < LANES; k++) begin
                mem_re[addr][k] <= wr_re[k];
                mem_im[addr][k] <= wr_im[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            rd_re[k] = mem_re[addr][k];
            rd_im[k] = mem_im[addr][k];
        end
    end

endmodule

// File: rtl/counter.sv
// counter: free-running up counter with enable, wraps at 2**WIDTH.
//   clk   system clock
//   rstn  asynchronous active-low reset, clears the count
//   en    advance the count by one on this edge
//   cnt   current count
module counter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bfly00_stage.sv
// bfly00_stage: stage-0 radix-2 butterfly of the 512-point, 16-lane FFT.
// The first half-frame (beats 0..15) is stored in a delay buffer; each beat
// of the second half-frame is paired lane-by-lane with the stored beat of
// the same index, and registered sum/difference outputs are produced with
// one bit of growth.
//
// Handshake: din_valid qualifies one input beat per clock; there is no
// back-pressure. twd00_valid is high for exactly the one cycle after a
// CALC beat is accepted and qualifies the sum/diff outputs of that beat.
// While twd00_valid is low the data outputs hold their last values.
//
//   clk                      system clock
//   rstn                     asynchronous active-low reset
//   din_valid                input beat qualifier
//   din_re, din_im           input lane samples, signed <3.6>
//   twd00_valid              output beat valid, feeds twd_mul00
//   o_00bfly_sum_re/_im      a + b per lane, signed <4.6>
//   o_00bfly_diff_re/_im     a - b per lane, signed <4.6>
//   dbg_state                current FSM state, for observation only
module bfly00_stage #(
    parameter int WIDTH      = 9,
    parameter int LANES      = 16,
    parameter int HALF_DEPTH = 16,
    parameter int CLK_CNT    = 5
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    din_valid,
    input  logic signed [WIDTH-1:0] din_re           [0:LANES-1],
    input  logic signed [WIDTH-1:0] din_im           [0:LANES-1],
    output logic                    twd00_valid,
    output logic signed [WIDTH:0]   o_00bfly_sum_re  [0:LANES-1],
    output logic signed [WIDTH:0]   o_00bfly_sum_im  [0:LANES-1],
    output logic signed [WIDTH:0]   o_00bfly_diff_re [0:LANES-1],
    output logic signed [WIDTH:0]   o_00bfly_diff_im [0:LANES-1],
    output fft_pkg::bfly_state_t    dbg_state
);

    import fft_pkg::*;

    localparam int AW = CLK_CNT - 1;

    bfly_state_t             state;
    logic [CLK_CNT-1:0]      beat_cnt;
    logic [AW-1:0]           addr;
    logic                    fill_last;
    logic                    calc_last;
    logic                    buf_we;
    logic signed [WIDTH-1:0] a_re [0:LANES-1];
    logic signed [WIDTH-1:0] a_im [0:LANES-1];

    counter #(
        .WIDTH(CLK_CNT)
    ) u_beat_cnt (
        .clk (clk),
        .rstn(rstn),
        .en  (din_valid),
        .cnt (beat_cnt)
    );

    assign addr   = beat_cnt[AW-1:0];
    assign buf_we = din_valid && (state == FILL);

    // Last beat of each half, judged on the full count so that the counter's
    // natural wrap at 2*HALF_DEPTH lines up with the return to FILL.
    assign fill_last = (beat_cnt == CLK_CNT'(HALF_DEPTH - 1));
    assign calc_last = (beat_cnt == CLK_CNT'(2 * HALF_DEPTH - 1));

    bfly00_dly_buf #(
        .WIDTH     (WIDTH),
        .LANES     (LANES),
        .HALF_DEPTH(HALF_DEPTH),
        .AW        (AW)
    ) u_dly_buf (
        .clk  (clk),
        .we   (buf_we),
        .addr (addr),
        .wr_re(din_re),
        .wr_im(din_im),
        .rd_re(a_re),
        .rd_im(a_im)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= FILL;
            twd00_valid <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                o_00bfly_sum_re[k]  <= '0;
                o_00bfly_sum_im[k]  <= '0;
                o_00bfly_diff_re[k] <= '0;
                o_00bfly_diff_im[k] <= '0;
            end
        end else begin
            twd00_valid <= 1'b0;
            if (din_valid) begin
                case (state)
                    FILL: begin
                        if (fill_last) state <= CALC;
                    end
                    CALC: begin
                        twd00_valid <= 1'b1;
                        // Explicit sign extension by one bit: with one bit
                        // of growth neither result can overflow.
                        for (int k = 0; k < LANES; k++) begin
                            o_00bfly_sum_re[k]  <= {a_re[k][WIDTH-1], a_re[k]} + {din_re[k][WIDTH-1], din_re[k]};
                            o_00bfly_sum_im[k]  <= {a_im[k][WIDTH-1], a_im[k]} + {din_im[k][WIDTH-1], din_im[k]};
                            o_00bfly_diff_re[k] <= {a_re[k][WIDTH-1], a_re[k]} - {din_re[k][WIDTH-1], din_re[k]};
                            o_00bfly_diff_im[k] <= {a_im[k][WIDTH-1], a_im[k]} - {din_im[k][WIDTH-1], din_im[k]};
                        end
                        if (calc_last) state <= FILL;
                    end
                    default: state <= FILL;
                endcase
            end
        end
    end

    assign dbg_state = state;

endmodule
